// File: rtl/aes_sched_pkg.sv
// Shared types and helpers for the AES request scheduler.
// Provides the scheduler state enum, the AES block width and the
// wrapping rotate-priority pick used by the round-robin arbiter.
package aes_sched_pkg;

    localparam int AES_BLK_W = 128;
    localparam int MAX_REQ   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } sched_state_e;

    // Returns {found, index}: first set bit of valid at or after ptr, wrapping at nreq.
    // Offsets are scanned from the far end so the nearest one is the last to assign.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 nreq);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = (int'(ptr) + k) % nreq;
                if (valid[3'(idx)]) begin
                    res = {1'b1, 3'(idx)};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational rotate-priority arbiter: picks the first valid requester at or
// after the pointer, wrapping NREQ-1 -> 0. The pointer register lives in the caller.
module aes_rr_arbiter
    import aes_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [3:0]         pick;

    // Widen the request vector and resolve the winner as one-hot plus index.
    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid;
        pick                  = rr_pick(valid_ext, 3'(ptr), NREQ);
        any                   = pick[3];
        idx                   = IDW'(pick[2:0]);
        gnt                   = '0;
        if (pick[3]) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares one AES core among NREQ requesters: one request per transaction,
// IDLE->LOAD->BUSY->RESP sequencing of the core ld/done handshake, response
// tagged with the requester id. Grants depend only on valid bits and state,
// never on key/text, so timing stays data independent.
// Build option AES_SCHED_FIXED_SLOT_EN: fixed time slots per requester instead
// of work-conserving round-robin (rsp_ready then ignored, RESP lasts one cycle).
module aes_req_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int IDW      = $clog2(NREQ),
    parameter int SLOT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*AES_BLK_W-1:0] req_key,
    input  logic [NREQ*AES_BLK_W-1:0] req_text,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [AES_BLK_W-1:0]      rsp_text,
    output logic                      core_ld,
    output logic [AES_BLK_W-1:0]      core_key,
    output logic [AES_BLK_W-1:0]      core_text_in,
    input  logic                      core_done,
    input  logic [AES_BLK_W-1:0]      core_text_out
);

    localparam logic [IDW-1:0] REQ_LAST = IDW'(NREQ - 1);

    if (NREQ < 2 || NREQ > MAX_REQ || SLOT_CYC < 4) begin : g_bad_cfg
        $error("aes_req_scheduler: unsupported NREQ/SLOT_CYC");
    end

    sched_state_e   state_q, state_d;
    logic           grant;
    logic [IDW-1:0] win;

`ifdef AES_SCHED_FIXED_SLOT_EN
    localparam int             SCW       = $clog2(SLOT_CYC);
    localparam logic [SCW-1:0] SLOT_LAST = SCW'(SLOT_CYC - 1);

    logic [SCW-1:0] slot_cnt_q;
    logic [IDW-1:0] slot_own_q;

    // Free-running slot timer; ownership rotates every slot regardless of activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
            slot_own_q <= '0;
        end else if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_q <= '0;
            slot_own_q <= (slot_own_q == REQ_LAST) ? '0 : slot_own_q + 1'b1;
        end else begin
            slot_cnt_q <= slot_cnt_q + 1'b1;
        end
    end

    assign win   = slot_own_q;
    assign grant = !rst && (state_q == IDLE) && (slot_cnt_q == '0) && req_valid[slot_own_q];

    // Only the slot owner can ever see a ready.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win] = 1'b1;
        end
    end
`else
    logic [IDW-1:0]  rr_ptr_q;
    logic [NREQ-1:0] arb_gnt;
    logic            arb_any;

    aes_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .idx   (win),
        .any   (arb_any)
    );

    assign grant     = !rst && (state_q == IDLE) && arb_any;
    assign req_ready = grant ? arb_gnt : '0;

    // Round-robin pointer moves past the winner only when a grant is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (grant) begin
            rr_ptr_q <= (win == REQ_LAST) ? '0 : win + 1'b1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; core_done outside BUSY has no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant) state_d = LOAD;
            LOAD: state_d = BUSY;
            BUSY: if (core_done) state_d = RESP;
            RESP: begin
`ifdef AES_SCHED_FIXED_SLOT_EN
                state_d = IDLE;
`else
                if (rsp_ready) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_ld   = (state_q == LOAD);
    assign rsp_valid = (state_q == RESP);

    // Capture the winner's operands at grant and the core result on completion;
    // both stay untouched until the next grant or done, which keeps them stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_key     <= '0;
            core_text_in <= '0;
            rsp_id       <= '0;
            rsp_text     <= '0;
        end else begin
            if (grant) begin
                core_key     <= req_key[AES_BLK_W*int'(win) +: AES_BLK_W];
                core_text_in <= req_text[AES_BLK_W*int'(win) +: AES_BLK_W];
                rsp_id       <= win;
            end
            if ((state_q == BUSY) && core_done) begin
                rsp_text <= core_text_out;
            end
        end
    end

endmodule
